// File: rtl/popcount_acc_ctrl.sv
// ---------------------------------------------------------------------------
// popcount_acc_ctrl
//   Streaming binary dot-product controller. For a job of `len` 64-bit words
//   it sums popcount(~(in_data ^ in_weight)) (the number of matching bits)
//   and reports both the raw match count and the +/-1 dot product
//   2*matches - 64*len.
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     start, len           job request (sampled only in IDLE) and word count
//     in_valid/in_ready    input word handshake, in_data / in_weight payload
//     out_valid/out_ready  result handshake
//     out_pop              unsigned match count for the job
//     out_dot              signed dot product for the job
//     busy                 high whenever the controller is not IDLE
//
//   Pipeline: popcount -> stage-1 register -> accumulator (stage 2). The
//   final sum is formed while draining, so the result appears two cycles
//   after the last input handshake.
// ---------------------------------------------------------------------------

// 64-bit population count: eight byte counts summed in a small adder tree.
//   data_i   64-bit word to count
//   count_o  number of ones (0..64)
module popcount64 (
    input  logic [63:0] data_i,
    output logic [6:0]  count_o
);
    logic [3:0] byte_cnt [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte
            always_comb begin
                byte_cnt[gi] = 4'd0;
                for (int b = 0; b < 8; b++) begin
                    byte_cnt[gi] = byte_cnt[gi] + {3'd0, data_i[gi*8+b]};
                end
            end
        end
    endgenerate

    logic [4:0] pair_cnt [4];
    logic [5:0] quad_cnt [2];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pair
            assign pair_cnt[gi] = {1'b0, byte_cnt[2*gi]} + {1'b0, byte_cnt[2*gi+1]};
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_quad
            assign quad_cnt[gi] = {1'b0, pair_cnt[2*gi]} + {1'b0, pair_cnt[2*gi+1]};
        end
    endgenerate

    assign count_o = {1'b0, quad_cnt[0]} + {1'b0, quad_cnt[1]};
endmodule

module popcount_acc_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [63:0]            in_data,
    input  logic [63:0]            in_weight,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_W+6:0]       out_pop,
    output logic signed [CNT_W+7:0] out_dot,
    output logic                   busy
);
    // 64*(2^CNT_W-1) < 2^(CNT_W+6), so one spare bit above that is ample.
    localparam int ACC_W = CNT_W + 7;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] len_q,    len_d;
    logic [CNT_W-1:0] rem_q,    rem_d;
    logic [ACC_W-1:0] acc_q,    acc_d;
    logic [6:0]       s1_q,     s1_d;
    logic             s1_vld_q, s1_vld_d;
    logic [ACC_W-1:0] pop_q,    pop_d;
    logic [ACC_W:0]   dot_q,    dot_d;

    logic [63:0]      xnor_word;
    logic [6:0]       match_cnt;
    logic             accept;
    logic [ACC_W-1:0] final_sum;
    logic [ACC_W+1:0] dot_wide;

    assign xnor_word = ~(in_data ^ in_weight);

    popcount64 u_popcount (
        .data_i  (xnor_word),
        .count_o (match_cnt)
    );

    assign in_ready  = (state_q == S_ACCUM) && (rem_q != '0);
    assign accept    = in_ready && in_valid;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_pop   = pop_q;
    assign out_dot   = $signed(dot_q);

    // Stage 2: fold in the stage-1 value only when it holds a real word, so
    // bubbles leave the accumulator untouched.
    assign final_sum = acc_q + (s1_vld_q ? {{(ACC_W-7){1'b0}}, s1_q} : '0);

    // 2*pop - 64*len computed one bit wider than the result so the borrow is
    // absorbed; the low ACC_W+1 bits are the correctly signed dot product.
    assign dot_wide = {1'b0, final_sum, 1'b0}
                    - {3'b000, len_q, 6'b000000};

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rem_d    = rem_q;
        acc_d    = final_sum;
        s1_d     = s1_q;
        s1_vld_d = 1'b0;
        pop_d    = pop_q;
        dot_d    = dot_q;

        if (accept) begin
            s1_d     = match_cnt;
            s1_vld_d = 1'b1;
            rem_d    = rem_q - 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d = len;
                    if (len != '0) begin
                        rem_d   = len;
                        acc_d   = '0;
                        state_d = S_ACCUM;
                    end else begin
                        pop_d   = '0;
                        dot_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_ACCUM: begin
                if (accept && (rem_q == {{(CNT_W-1){1'b0}}, 1'b1})) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The last word sits in stage 1; this edge empties both
                // stages, so the completed sum is captured for the result.
                pop_d   = final_sum;
                dot_d   = dot_wide[ACC_W:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
            pop_q    <= '0;
            dot_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            rem_q    <= rem_d;
            acc_q    <= acc_d;
            s1_q     <= s1_d;
            s1_vld_q <= s1_vld_d;
            pop_q    <= pop_d;
            dot_q    <= dot_d;
        end
    end
endmodule

// File: tb/tb_popcount_acc_ctrl.sv
module tb_popcount_acc_ctrl;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [15:0]        len = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [63:0]        in_data = '0;
    logic [63:0]        in_weight = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [22:0]        out_pop;
    logic signed [23:0] out_dot;
    logic               busy;

    popcount_acc_ctrl #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_weight (in_weight),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pop   (out_pop),
        .out_dot   (out_dot),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint pop;
        longint dot;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          hs_count = 0;
    logic [63:0] dq[$];
    logic [63:0] wq[$];
    bit          vp[$];

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: counts input handshakes and checks every delivered result
    // against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) hs_count++;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_pop", longint'(out_pop), e.pop);
                chk("out_dot", longint'(out_dot), e.dot);
                $display("result: pop=%0d dot=%0d (expected %0d / %0d)",
                         out_pop, out_dot, e.pop, e.dot);
            end
        end
    end

    // Runs one job from dq/wq with in_valid pattern vp (then solid valid).
    task automatic run_job(input int n, input longint ep, input longint edot);
        int idx = 0;
        int p = 0;
        int guard = 0;
        int hs0;
        bit hand;
        exp_t e;
        hs0 = hs_count;
        e.pop = ep;
        e.dot = edot;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b1;
        len = n[15:0];
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) begin
            @(negedge clk);
            chk("zero_len_valid", longint'(out_valid), 1);
            chk("zero_len_ready", longint'(in_ready), 0);
        end else begin
            while (idx < n && guard < 200) begin
                in_valid  = (p < vp.size()) ? vp[p] : 1'b1;
                in_data   = dq[idx];
                in_weight = wq[idx];
                @(negedge clk);
                hand = in_valid && in_ready;
                @(posedge clk); #1;
                if (hand) idx++;
                p++;
                guard++;
            end
            in_valid = 1'b0;
            if (guard >= 200) chk("input_timeout", guard, 0);
            @(negedge clk);
            chk("drain_valid_low", longint'(out_valid), 0);
            @(negedge clk);
            chk("latency_valid", longint'(out_valid), 1);
        end
        @(posedge clk); #1;
        chk("handshakes", hs_count - hs0, n);
        $display("job len=%0d issued, expect pop=%0d dot=%0d", n, ep, edot);
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_out_pop", longint'(out_pop), 0);
        chk("rst_out_dot", longint'(out_dot), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // All ones, one word: 64 matches
        dq = '{ONES}; wq = '{ONES}; vp = '{};
        run_job(1, 64, 64);

        // Match counts 64, 0, 32
        dq = '{ONES, ONES, 64'h0000_0000_FFFF_FFFF};
        wq = '{ONES, 64'h0, 64'h0};
        run_job(3, 96, 0);

        // Empty job
        run_job(0, 0, 0);

        // All mismatches: negative dot product
        dq = '{ONES, ONES}; wq = '{64'h0, 64'h0};
        run_job(2, 0, -128);

        // Bubbles, then the same words back-to-back: 64+0+56+56
        dq = '{64'h0, ONES, 64'hFF, 64'h0F};
        wq = '{64'h0, 64'h0, 64'h0, 64'hF0};
        vp = '{1, 0, 0, 1, 1, 0, 1};
        run_job(4, 176, 96);
        vp = '{};
        run_job(4, 176, 96);

        // Consumer stalls for 5 cycles; start pulsed meanwhile is ignored
        out_ready = 1'b0;
        dq = '{64'hFF}; wq = '{64'h0};
        run_job(1, 56, 48);
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            len = 16'd7;
            @(negedge clk);
            chk("hold_valid", longint'(out_valid), 1);
            chk("hold_pop", longint'(out_pop), 56);
            chk("hold_dot", longint'(out_dot), 48);
            chk("hold_in_ready", longint'(in_ready), 0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", longint'(busy), 0);
        chk("idle_out_valid", longint'(out_valid), 0);
        @(posedge clk); #1;
        chk("start_ignored_busy", longint'(busy), 0);

        // Reset mid-job after 2 of 5 words
        @(posedge clk); #1;
        start = 1'b1;
        len = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        in_data = ONES;
        in_weight = ONES;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_in_ready", longint'(in_ready), 0);
        chk("midrst_out_pop", longint'(out_pop), 0);
        chk("midrst_out_dot", longint'(out_dot), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dq = '{64'h1}; wq = '{64'h0};
        run_job(1, 63, 62);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
